// File: rtl/anim_pkg.sv
// Shared definitions for the sprite animation engine: FSM state encoding,
// colour width, default screen geometry and a counter-width helper.
package anim_pkg;

  localparam int COLOUR_W     = 3;
  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DRAW      = 3'd1,
    ST_WAIT_TICK = 3'd2,
    ST_ERASE     = 3'd3,
    ST_MOVE      = 3'd4
  } anim_state_e;

  // Bits needed to hold the values 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Frame-rate divider: counts TICK_DIV-1 down to 0 and reloads, raising tick
// for the single cycle in which the count sits at zero.
module tick_divider
  import anim_pkg::*;
#(
  parameter int TICK_DIV = 833333
) (
  input  logic clk,
  input  logic resetn,
  output logic tick
);

  localparam int            CW     = cnt_width(TICK_DIV);
  localparam logic [CW-1:0] RELOAD = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [CW-1:0] ZERO   = CW'(0);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: reload after reaching zero, otherwise count down.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q == ZERO) begin
      cnt_d = RELOAD;
    end else begin
      cnt_d = cnt_q - ONE;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == ZERO);

endmodule

// File: rtl/sprite_mover.sv
// Erase/draw animation engine: moves one solid rectangle right-to-left across
// the frame, one pixel write per cycle on the VGA adapter plot interface.
module sprite_mover
  import anim_pkg::*;
#(
  parameter int                  SCREEN_W  = DEF_SCREEN_W,
  parameter int                  SCREEN_H  = DEF_SCREEN_H,
  parameter int                  XW        = 8,
  parameter int                  YW        = 7,
  parameter int                  SPR_W     = 4,
  parameter int                  SPR_H     = 4,
  parameter int                  STEP      = 1,
  parameter int                  TICK_DIV  = 833333,
  parameter logic [COLOUR_W-1:0] BG_COLOUR = 3'b000
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                go,
  input  logic [YW-1:0]       y_start,
  input  logic [COLOUR_W-1:0] colour,
  input  logic                pause,
  output logic [XW-1:0]       x_out,
  output logic [YW-1:0]       y_out,
  output logic [COLOUR_W-1:0] colour_out,
  output logic                plot,
  output logic                busy,
  output logic                exited
);

  localparam int             PXW     = cnt_width(SPR_W);
  localparam int             PYW     = cnt_width(SPR_H);
  localparam logic [PXW-1:0] PX_LAST = PXW'(SPR_W - 1);
  localparam logic [PYW-1:0] PY_LAST = PYW'(SPR_H - 1);
  localparam logic [PXW-1:0] PX_ZERO = PXW'(0);
  localparam logic [PYW-1:0] PY_ZERO = PYW'(0);
  localparam logic [PXW-1:0] PX_ONE  = PXW'(1);
  localparam logic [PYW-1:0] PY_ONE  = PYW'(1);
  localparam logic [XW-1:0]  X_START = XW'(SCREEN_W - SPR_W);
  localparam logic [YW-1:0]  Y_MAX   = YW'(SCREEN_H - SPR_H);
  localparam logic [XW-1:0]  STEP_X  = XW'(STEP);

  anim_state_e         state_q, state_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [COLOUR_W-1:0] col_q, col_d;
  logic [PXW-1:0]      px_q, px_d;
  logic [PYW-1:0]      py_q, py_d;
  logic                tick_pend_q, tick_pend_d;

  logic tick_s;
  logic scan_s;
  logic last_pix_s;
  logic exit_s;

  tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_divider (
    .clk    (clk),
    .resetn (resetn),
    .tick   (tick_s)
  );

  assign scan_s     = (state_q == ST_DRAW) || (state_q == ST_ERASE);
  assign last_pix_s = (px_q == PX_LAST) && (py_q == PY_LAST);
  // The sprite leaves the frame when another step would go below column 0.
  assign exit_s     = (32'(x_q) < 32'(STEP));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a pass always runs to its last pixel; pause only holds WAIT_TICK.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d = ST_DRAW;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAW: begin
        if (last_pix_s) begin
          state_d = ST_WAIT_TICK;
        end else begin
          state_d = ST_DRAW;
        end
      end
      ST_WAIT_TICK: begin
        if (tick_pend_q && !pause) begin
          state_d = ST_ERASE;
        end else begin
          state_d = ST_WAIT_TICK;
        end
      end
      ST_ERASE: begin
        if (last_pix_s) begin
          state_d = ST_MOVE;
        end else begin
          state_d = ST_ERASE;
        end
      end
      ST_MOVE: begin
        if (exit_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAW;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode straight from registered state and counters (no added latency).
  always_comb begin
    plot       = 1'b0;
    busy       = (state_q != ST_IDLE);
    exited     = 1'b0;
    colour_out = {COLOUR_W{1'b0}};
    x_out      = x_q + XW'(px_q);
    y_out      = y_q + YW'(py_q);
    case (state_q)
      ST_DRAW: begin
        plot       = 1'b1;
        colour_out = col_q;
      end
      ST_ERASE: begin
        plot       = 1'b1;
        colour_out = BG_COLOUR;
      end
      ST_MOVE: begin
        exited = exit_s;
      end
      default: begin
        plot       = 1'b0;
        colour_out = {COLOUR_W{1'b0}};
      end
    endcase
  end

  // Scan counters: px fastest, py slowest; both sit at zero outside a pass.
  always_comb begin
    px_d = PX_ZERO;
    py_d = PY_ZERO;
    if (scan_s) begin
      if (px_q == PX_LAST) begin
        px_d = PX_ZERO;
        if (py_q == PY_LAST) begin
          py_d = PY_ZERO;
        end else begin
          py_d = py_q + PY_ONE;
        end
      end else begin
        px_d = px_q + PX_ONE;
        py_d = py_q;
      end
    end else begin
      px_d = PX_ZERO;
      py_d = PY_ZERO;
    end
  end

  // Position/colour capture on an accepted go, and the leftward step in MOVE.
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    col_d = col_q;
    if ((state_q == ST_IDLE) && go) begin
      x_d   = X_START;
      y_d   = (y_start > Y_MAX) ? Y_MAX : y_start;
      col_d = colour;
    end else if ((state_q == ST_MOVE) && !exit_s) begin
      x_d = x_q - STEP_X;
    end else begin
      x_d = x_q;
    end
  end

  // Pending-tick flag: any number of ticks collapses into one pending frame step.
  always_comb begin
    tick_pend_d = tick_pend_q;
    if (state_q == ST_IDLE) begin
      tick_pend_d = 1'b0;
    end else if ((state_q == ST_WAIT_TICK) && (state_d == ST_ERASE)) begin
      tick_pend_d = 1'b0;
    end else if (tick_s) begin
      tick_pend_d = 1'b1;
    end else begin
      tick_pend_d = tick_pend_q;
    end
  end

  // Datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      x_q         <= {XW{1'b0}};
      y_q         <= {YW{1'b0}};
      col_q       <= {COLOUR_W{1'b0}};
      px_q        <= PX_ZERO;
      py_q        <= PY_ZERO;
      tick_pend_q <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      col_q       <= col_d;
      px_q        <= px_d;
      py_q        <= py_d;
      tick_pend_q <= tick_pend_d;
    end
  end

endmodule

// File: tb/tb_sprite_mover.sv
// Self-checking bench for sprite_mover on a 16x12 frame with a 2x2 sprite,
// STEP=4 and a 20-cycle frame tick.
module tb_sprite_mover;

  localparam int SW   = 16;
  localparam int SH   = 12;
  localparam int SPW  = 2;
  localparam int SPH  = 2;
  localparam int STP  = 4;
  localparam int TD   = 20;
  localparam int XW   = 8;
  localparam int YW   = 7;
  localparam int NPIX = SPW * SPH;

  logic          clk;
  logic          resetn;
  logic          go;
  logic          pause;
  logic [YW-1:0] y_start;
  logic [2:0]    colour;
  logic [XW-1:0] x_out;
  logic [YW-1:0] y_out;
  logic [2:0]    colour_out;
  logic          plot;
  logic          busy;
  logic          exited;

  int n_cmp = 0;
  int n_bad = 0;
  int since_rst = 0;

  typedef struct {
    logic [YW-1:0] ys;
    logic [2:0]    col;
    logic [YW-1:0] exp_y;
  } vec_t;

  vec_t vecs[6];

  sprite_mover #(
    .SCREEN_W (SW), .SCREEN_H (SH), .XW (XW), .YW (YW),
    .SPR_W (SPW), .SPR_H (SPH), .STEP (STP), .TICK_DIV (TD),
    .BG_COLOUR (3'b000)
  ) dut (
    .clk (clk), .resetn (resetn), .go (go), .y_start (y_start),
    .colour (colour), .pause (pause), .x_out (x_out), .y_out (y_out),
    .colour_out (colour_out), .plot (plot), .busy (busy), .exited (exited)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge index since reset release: a frame tick lands on every edge whose index is a multiple of TD.
  always @(posedge clk) begin
    if (!resetn) since_rst <= 0;
    else         since_rst <= since_rst + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0; go = 1'b0; pause = 1'b0;
    step();
    step();
    check("reset_outputs", {plot, busy, exited, x_out, y_out}, 32'd0);
    resetn = 1'b1;
  endtask

  // Checks one full pass starting at the current cycle; returns one cycle after its last pixel.
  task automatic expect_pass(input int x, input int y, input logic [2:0] col, input string name);
    logic [18:0] exp;
    for (int i = 0; i < NPIX; i++) begin
      exp = {1'b1, XW'(x + (i % SPW)), YW'(y + (i / SPW)), col};
      check(name, {plot, x_out, y_out, colour_out}, exp);
      step();
    end
  endtask

  task automatic wait_plot(input int budget, input string name);
    int n;
    n = 0;
    while (!plot && n < budget) begin
      step();
      n++;
    end
    check(name, {31'd0, plot}, 32'd1);
  endtask

  initial begin
    int np;
    int w;
    int yc;
    int exits;
    int guard;
    bit done;
    logic [17:0] q[$];
    logic [17:0] e;
    logic [YW-1:0] ys;
    logic [2:0] col;

    resetn = 1'b0; go = 1'b0; pause = 1'b0; y_start = '0; colour = '0;

    vecs[0] = '{ys: 7'd5,   col: 3'b100, exp_y: 7'd5};
    vecs[1] = '{ys: 7'd100, col: 3'b001, exp_y: 7'd10};
    vecs[2] = '{ys: 7'd10,  col: 3'b111, exp_y: 7'd10};
    vecs[3] = '{ys: 7'd11,  col: 3'b010, exp_y: 7'd10};
    vecs[4] = '{ys: 7'd0,   col: 3'b011, exp_y: 7'd0};
    vecs[5] = '{ys: 7'd127, col: 3'b110, exp_y: 7'd10};

    // Reset, first draw, first erase/move, free run to exit.
    do_reset();
    y_start = 7'd5; colour = 3'b100; go = 1'b1;
    step();
    go = 1'b0;
    check("busy_after_go", {31'd0, busy}, 32'd1);
    expect_pass(14, 5, 3'b100, "draw_x14");
    check("wait_no_plot", {30'd0, plot, busy}, 32'd1);
    wait_plot(3 * TD, "first_tick_timeout");
    expect_pass(14, 5, 3'b000, "erase_x14");
    check("move_cycle", {29'd0, plot, busy, exited}, 32'd2);
    step();
    for (int fx = 10; fx >= 0; fx -= STP) begin
      expect_pass(fx, 5, 3'b100, "draw_run");
      wait_plot(3 * TD, "run_tick_timeout");
      expect_pass(fx, 5, 3'b000, "erase_run");
      check("move_run", {29'd0, plot, busy, exited}, {29'd0, 1'b0, 1'b1, (fx < STP)});
      step();
    end
    check("idle_after_exit", {29'd0, plot, busy, exited}, 32'd0);
    np = 0;
    for (int i = 0; i < 3 * TD; i++) begin
      step();
      if (plot || exited) np++;
    end
    check("no_plot_after_exit", np, 0);

    // Pause across several ticks, then exactly one frame step.
    y_start = 7'd3; colour = 3'b010; go = 1'b1;
    step();
    go = 1'b0;
    expect_pass(14, 3, 3'b010, "draw_pause");
    pause = 1'b1;
    np = 0;
    for (int i = 0; i < 3 * TD + 5; i++) begin
      step();
      if (plot) np++;
    end
    check("paused_no_plot", np, 0);
    w = 0;
    while ((since_rst % TD) != 2 && w < 2 * TD) begin
      step();
      w++;
    end
    pause = 1'b0;
    step();
    expect_pass(14, 3, 3'b000, "erase_after_pause");
    check("move_after_pause", {29'd0, plot, busy, exited}, 32'd2);
    step();
    expect_pass(10, 3, 3'b010, "draw_after_pause");
    w = 0;
    while (!plot && w < 3 * TD) begin
      step();
      w++;
    end
    check("collapsed_wait_len", w, 10);
    expect_pass(10, 3, 3'b000, "erase_next_frame");

    // Table: y clamping, go ignored while busy, reset mid-draw.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      y_start = vecs[v].ys; colour = vecs[v].col; go = 1'b1;
      step();
      check("tbl_px0", {busy, plot, x_out, y_out, colour_out},
            {1'b1, 1'b1, 8'd14, vecs[v].exp_y, vecs[v].col});
      y_start = 7'd0; colour = ~vecs[v].col;
      step();
      go = 1'b0;
      check("tbl_px1", {plot, x_out, y_out, colour_out}, {1'b1, 8'd15, vecs[v].exp_y, vecs[v].col});
      step();
      check("tbl_px2", {plot, x_out, y_out, colour_out},
            {1'b1, 8'd14, vecs[v].exp_y + 7'd1, vecs[v].col});
      resetn = 1'b0;
      step();
      check("tbl_reset_mid_draw", {29'd0, plot, busy, exited}, 32'd0);
    end

    // Randomized runs against a pixel-stream model of the whole flight.
    for (int r = 0; r < 5; r++) begin
      do_reset();
      ys  = 7'($urandom_range(0, 127));
      col = 3'($urandom_range(1, 7));
      yc  = (int'(ys) > SH - SPH) ? SH - SPH : int'(ys);
      q.delete();
      for (int x = SW - SPW; x >= 0; x -= STP) begin
        for (int i = 0; i < NPIX; i++) q.push_back({XW'(x + i % SPW), YW'(yc + i / SPW), col});
        for (int i = 0; i < NPIX; i++) q.push_back({XW'(x + i % SPW), YW'(yc + i / SPW), 3'b000});
      end
      y_start = ys; colour = col; go = 1'b1;
      step();
      go = 1'b0;
      exits = 0; guard = 0; done = 1'b0;
      while (!done && guard < 3000) begin
        if (plot) begin
          if (q.size() == 0) begin
            check("rnd_extra_plot", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            check("rnd_pixel", {x_out, y_out, colour_out}, e);
          end
        end
        if (exited) begin
          exits++;
          check("rnd_exit_all_drawn", q.size(), 0);
        end
        if (!busy) begin
          done = 1'b1;
        end else begin
          pause   = ($urandom_range(0, 1) == 1);
          go      = (exits == 0) && ($urandom_range(0, 3) == 0);
          y_start = 7'($urandom);
          colour  = 3'($urandom);
          step();
          guard++;
        end
      end
      go = 1'b0; pause = 1'b0;
      check("rnd_finished", {31'd0, done}, 32'd1);
      check("rnd_exit_count", exits, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
